// File: rtl/dmem_pkg.sv
// Shared types and default constants for the data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_DEPTH   = 32;
   localparam int DEF_LATENCY = 2;

   // Wait-state counter width; holds LATENCY-1 for LATENCY up to 15.
   localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Word store: synchronous write, registered read, synchronous clear of every word.
module dmem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic              re,
   input  logic              rd_clr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage and read register; reset clears everything, a read beats a clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rdata <= '0;
      end else begin
         if (we) begin
            mem[addr] <= wdata;
         end
         if (re) begin
            rdata <= mem[addr];
         end else if (rd_clr) begin
            rdata <= '0;
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the data-memory load/store interface with programmable wait states.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int ADDR_W  = 5,
   parameter int LATENCY = DEF_LATENCY
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
);

   localparam logic [31:0]      DEPTH_L  = 32'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               wr_q;
   logic [31:0]        addr_q;
   logic [DATA_W-1:0]  wdata_q;

   logic               accept;
   logic               resp_done;
   logic               access_now;
   logic               acc_wr;
   logic [31:0]        acc_addr;
   logic [DATA_W-1:0]  acc_wdata;
   logic               acc_err;

   assign accept    = (state_q == IDLE) && req_valid;
   assign resp_done = (state_q == RESP) && resp_ready;

   // With zero wait states the access uses the request fields at the acceptance edge;
   // otherwise it uses the latched copy when the counter expires.
   assign access_now = (LATENCY == 0) ? accept : ((state_q == WAIT) && (cnt_q == '0));
   assign acc_wr     = (LATENCY == 0) ? req_write : wr_q;
   assign acc_addr   = (LATENCY == 0) ? req_addr  : addr_q;
   assign acc_wdata  = (LATENCY == 0) ? req_wdata : wdata_q;

   // Full 32-bit range check so out-of-range indices never alias onto real words.
   assign acc_err = (acc_addr >= DEPTH_L);

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode; a response handshake returns to IDLE without taking a new request.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = (LATENCY == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Wait-state counter: loaded on acceptance, counts down to zero in WAIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (accept && (LATENCY != 0)) begin
         cnt_q <= CNT_LOAD;
      end else if ((state_q == WAIT) && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // Request capture; pure data, only meaningful while a request is in flight.
   always_ff @(posedge clk) begin
      if (accept) begin
         wr_q    <= req_write;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   // Error flag set at the access edge and dropped when the response is taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         resp_err <= 1'b0;
      end else if (access_now) begin
         resp_err <= acc_err;
      end else if (resp_done) begin
         resp_err <= 1'b0;
      end
   end

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk    (clk),
      .reset  (reset),
      .we     (access_now && acc_wr && !acc_err),
      .re     (access_now && !acc_wr && !acc_err),
      .rd_clr ((access_now && (acc_wr || acc_err)) || resp_done),
      .addr   (acc_addr[ADDR_W-1:0]),
      .wdata  (acc_wdata),
      .rdata  (resp_rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=2 instance plus a LATENCY=0 instance.
module tb_dmem_responder;

   localparam int LAT = 2;

   typedef struct packed {
      logic        err;
      logic [31:0] rd;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;

   logic        req_valid0, req_ready0, req_write0;
   logic [31:0] req_addr0, req_wdata0;
   logic        resp_valid0, resp_ready0, resp_err0;
   logic [31:0] resp_rdata0;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb_q[$];
   exp_t sb0_q[$];

   always #5 clk = ~clk;

   dmem_responder #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .LATENCY(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   dmem_responder #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .LATENCY(0)) dut0 (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid0),
      .req_ready  (req_ready0),
      .req_write  (req_write0),
      .req_addr   (req_addr0),
      .req_wdata  (req_wdata0),
      .resp_valid (resp_valid0),
      .resp_ready (resp_ready0),
      .resp_rdata (resp_rdata0),
      .resp_err   (resp_err0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_tests++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
      end
   endtask

   // Present a request, wait for it to be accepted, record the expected response.
   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
      int   n;
      exp_t e;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      e.err = exp_err;
      e.rd  = exp_rd;
      sb_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Called at the negedge after acceptance; counts negedges until resp_valid and compares.
   task automatic wait_resp();
      int   lat;
      exp_t e;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'(LAT + 1));
      if (sb_q.size() == 0) begin
         chk("sb_nonempty", 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk("rdata", resp_rdata, e.rd);
         chk("err", 32'(resp_err), 32'(e.err));
      end
   endtask

   // Hold off the response for some cycles (with a competing request), then take it.
   task automatic collect(input int hold);
      logic [31:0] rd_seen;
      wait_resp();
      rd_seen = resp_rdata;
      if (hold > 0) begin
         req_valid = 1'b1;
         req_write = 1'b1;
         req_addr  = 32'd3;
         req_wdata = 32'h77;
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("bp_valid", 32'(resp_valid), 32'd1);
         chk("bp_rdata", resp_rdata, rd_seen);
         chk("bp_ready", 32'(req_ready), 32'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      chk("clr_valid", 32'(resp_valid), 32'd0);
      chk("clr_rdata", resp_rdata, 32'd0);
      chk("clr_err", 32'(resp_err), 32'd0);
   endtask

   task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
      issue(wr, addr, wd, exp_rd, exp_err);
      collect(0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e0;
      reset       = 1'b1;
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_addr    = '0;
      req_wdata   = '0;
      resp_ready  = 1'b0;
      req_valid0  = 1'b0;
      req_write0  = 1'b0;
      req_addr0   = '0;
      req_wdata0  = '0;
      resp_ready0 = 1'b1;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_err", 32'(resp_err), 32'd0);
      chk("rst_req_ready0", 32'(req_ready0), 32'd1);
      reset = 1'b0;

      // Every word reads back zero after reset
      for (int a = 0; a < 32; a++) begin
         txn(1'b0, 32'(a), 32'd0, 32'd0, 1'b0);
      end

      // Store then load, read-after-write
      txn(1'b1, 32'd0, 32'h0000000B, 32'd0, 1'b0);
      txn(1'b0, 32'd0, 32'd0, 32'h0000000B, 1'b0);

      // Out-of-range addresses do not alias
      txn(1'b1, 32'd8, 32'h88, 32'd0, 1'b0);
      txn(1'b1, 32'd40, 32'hDEAD, 32'd0, 1'b1);
      txn(1'b0, 32'd8, 32'd0, 32'h88, 1'b0);
      txn(1'b0, 32'd40, 32'd0, 32'd0, 1'b1);
      txn(1'b0, 32'h8000_0008, 32'd0, 32'd0, 1'b1);

      // Back-pressure with a competing request that must not be accepted
      txn(1'b1, 32'd3, 32'h5, 32'd0, 1'b0);
      issue(1'b0, 32'd3, 32'd0, 32'h5, 1'b0);
      collect(6);
      txn(1'b0, 32'd3, 32'd0, 32'h5, 1'b0);

      // Response handshake and new request in the same cycle
      issue(1'b0, 32'd0, 32'd0, 32'h0000000B, 1'b0);
      wait_resp();
      resp_ready = 1'b1;
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_addr   = 32'd8;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      chk("sim_req_ready", 32'(req_ready), 32'd1);
      chk("sim_resp_valid", 32'(resp_valid), 32'd0);
      @(posedge clk);
      e0.err = 1'b0;
      e0.rd  = 32'h88;
      sb_q.push_back(e0);
      @(negedge clk);
      req_valid = 1'b0;
      chk("sim_accepted", 32'(req_ready), 32'd0);
      collect(0);

      // Reset during WAIT (d=1) and on the scheduled access edge (d=2)
      for (int d = 1; d <= 2; d++) begin
         @(negedge clk);
         req_valid = 1'b1;
         req_write = 1'b1;
         req_addr  = 32'd7;
         req_wdata = 32'hFFFF;
         @(posedge clk);
         @(negedge clk);
         req_valid = 1'b0;
         repeat (d - 1) @(negedge clk);
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         chk("rstw_req_ready", 32'(req_ready), 32'd1);
         chk("rstw_resp_valid", 32'(resp_valid), 32'd0);
         txn(1'b0, 32'd7, 32'd0, 32'd0, 1'b0);
      end

      // LATENCY=0 instance: back-to-back requests with resp_ready tied high
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         chk("l0_idle_ready", 32'(req_ready0), 32'd1);
         chk("l0_idle_valid", 32'(resp_valid0), 32'd0);
         req_valid0 = 1'b1;
         if (i < 4) begin
            req_write0 = 1'b1;
            req_addr0  = 32'(i);
            req_wdata0 = 32'h100 + 32'(i);
            e0.rd      = 32'd0;
         end else begin
            req_write0 = 1'b0;
            req_addr0  = 32'(i - 4);
            req_wdata0 = 32'd0;
            e0.rd      = 32'h100 + 32'(i - 4);
         end
         e0.err = 1'b0;
         sb0_q.push_back(e0);
         @(negedge clk);
         chk("l0_resp_ready", 32'(req_ready0), 32'd0);
         chk("l0_resp_valid", 32'(resp_valid0), 32'd1);
         e0 = sb0_q.pop_front();
         chk("l0_rdata", resp_rdata0, e0.rd);
         chk("l0_err", 32'(resp_err0), 32'(e0.err));
         @(negedge clk);
      end
      req_valid0 = 1'b0;

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      chk("sb0_drained", 32'(sb0_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
